// File: rtl/myproject_mul_pipe_sat.sv
// Pipelined signed multiplier with ready/valid flow control, rounding right-shift
// and optional saturation; the rescaled result and its overflow flag leave the last stage.
module myproject_mul_pipe_sat #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 10,
    parameter int dout_WIDTH = 25,
    parameter int NUM_STAGE  = 2,
    parameter int SHIFT      = 0,
    parameter int SAT        = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int P_W = din0_WIDTH + din1_WIDTH;
    localparam int R_W = dout_WIDTH + 1;
    localparam int SH1 = (SHIFT > 0) ? SHIFT - 1 : 0;

    // One extra bit keeps the rounding add of the most-negative corner product exact.
    localparam logic signed [P_W:0] HALF = (SHIFT > 0) ? ((P_W+1)'(1) << SH1) : '0;
    localparam logic signed [P_W:0] MAXV = {{(P_W+2-dout_WIDTH){1'b0}}, {(dout_WIDTH-1){1'b1}}};
    localparam logic signed [P_W:0] MINV = ~MAXV;

    if (NUM_STAGE < 1 || NUM_STAGE > 6 || SHIFT < 0 || SHIFT > P_W - 2 ||
        dout_WIDTH < 2 || dout_WIDTH > P_W || ID < 0) begin : g_bad_param
        $error("myproject_mul_pipe_sat: illegal parameter set");
    end

    // Returns {ovf, result}: round half toward +inf, then clamp or wrap.
    function automatic logic [R_W-1:0] rescale(input logic signed [P_W-1:0] p);
        logic signed [P_W:0]     r;
        logic                    hi;
        logic                    lo;
        logic [dout_WIDTH-1:0]   d;
        r = {p[P_W-1], p};
        if (SHIFT > 0) r = (r + HALF) >>> SHIFT;
        hi = (r > MAXV);
        lo = (r < MINV);
        d  = r[dout_WIDTH-1:0];
        if (SAT != 0) begin
            if (hi)      d = MAXV[dout_WIDTH-1:0];
            else if (lo) d = MINV[dout_WIDTH-1:0];
        end
        return {hi | lo, d};
    endfunction

    logic signed [P_W-1:0]  prod_d;
    logic signed [P_W-1:0]  prod_q;
    logic [NUM_STAGE-1:0]   vld;
    logic [NUM_STAGE-1:0]   adv;
    logic                   chain;
    logic [R_W-1:0]         res_out;

    assign prod_d = $signed(din0) * $signed(din1);

    // A stage may move when it is empty or everything downstream of it moves.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        adv   = '0;
        chain = out_rdy;
        for (int k = NUM_STAGE - 1; k >= 0; k--) begin
            chain  = chain || !vld[k];
            adv[k] = chain;
        end
    end

    assign in_rdy = adv[0];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so stage k reads the pre-edge value of stage k-1.
        if (!ap_rst_n) begin
            vld <= '0;
        end else begin
            if (adv[0]) vld[0] <= in_vld;
            for (int k = 1; k < NUM_STAGE; k++) begin
                if (adv[k]) vld[k] <= vld[k-1];
            end
        end
    end

    // NOTE: datapath registers carry no reset; the valid bits alone decide what is visible.
    always_ff @(posedge ap_clk) begin
        if (adv[0] && in_vld) prod_q <= prod_d;
    end

    if (NUM_STAGE == 1) begin : g_one
        assign res_out = rescale(prod_q);
    end else begin : g_multi
        logic [R_W-1:0] res_q [1:NUM_STAGE-1];

        always_ff @(posedge ap_clk) begin
            if (adv[1] && vld[0]) res_q[1] <= rescale(prod_q);
            for (int k = 2; k < NUM_STAGE; k++) begin
                if (adv[k] && vld[k-1]) res_q[k] <= res_q[k-1];
            end
        end

        assign res_out = res_q[NUM_STAGE-1];
    end

    // Gating keeps dout/ovf at zero while the output stage is empty or in reset.
    assign out_vld      = vld[NUM_STAGE-1];
    assign {ovf, dout}  = out_vld ? res_out : '0;

endmodule

// File: tb/tb_myproject_mul_pipe_sat.sv
// Self-checking bench: six parameter variants share one stimulus stream; a per-instance
// scoreboard fed by an arithmetic reference model checks every result in order.
module tb_myproject_mul_pipe_sat;

    localparam int ND = 6;
    localparam int NS [ND] = '{2, 2, 2, 4, 3, 1};
    localparam int SH [ND] = '{0, 0, 4, 0, 0, 0};
    localparam int SA [ND] = '{1, 0, 1, 1, 1, 1};

    logic        clk;
    logic        rst_n;
    logic        in_vld;
    logic        out_rdy;
    logic [15:0] din0;
    logic [9:0]  din1;

    wire         in_rdy_w  [ND];
    wire         out_vld_w [ND];
    wire         ovf_w     [ND];
    wire [24:0]  dout_w    [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        myproject_mul_pipe_sat #(
            .ID(g), .din0_WIDTH(16), .din1_WIDTH(10), .dout_WIDTH(25),
            .NUM_STAGE(NS[g]), .SHIFT(SH[g]), .SAT(SA[g])
        ) u_dut (
            .ap_clk  (clk),
            .ap_rst_n(rst_n),
            .in_vld  (in_vld),
            .in_rdy  (in_rdy_w[g]),
            .din0    (din0),
            .din1    (din1),
            .out_vld (out_vld_w[g]),
            .out_rdy (out_rdy),
            .dout    (dout_w[g]),
            .ovf     (ovf_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: exact product, floor((P + 2^(s-1)) / 2^s), then clamp or modulo 2^dw.
    function automatic void model(input longint a, input longint b, input int sh, input int sat,
                                  input int dw, output longint d, output bit o);
        longint p, r, q, mx, mn, m;
        p = a * b;
        r = p;
        if (sh > 0) begin
            q = longint'(1) << sh;
            r = p + q / 2;
            if (r >= 0) r = r / q;
            else        r = -((-r + q - 1) / q);
        end
        mx = (longint'(1) << (dw - 1)) - 1;
        mn = -mx - 1;
        o  = (r > mx) || (r < mn);
        if (sat != 0) begin
            d = (r > mx) ? mx : (r < mn) ? mn : r;
        end else begin
            m = longint'(1) << dw;
            d = r % m;
            if (d > mx) d -= m;
            if (d < mn) d += m;
        end
    endfunction

    longint      exp_d [ND][$];
    bit          exp_o [ND][$];
    bit          stall_seen [ND];
    logic [24:0] held_d [ND];
    logic        held_o [ND];
    int          cons_cnt [ND];
    longint      md;
    bit          mo;

    always @(negedge rst_n) begin
        for (int k = 0; k < ND; k++) begin
            exp_d[k].delete();
            exp_o[k].delete();
            stall_seen[k] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (!rst_n) begin
                check($sformatf("rst_out_vld_d%0d", k), out_vld_w[k], 0);
                check($sformatf("rst_in_rdy_d%0d", k), in_rdy_w[k], 1);
                check($sformatf("rst_dout_d%0d", k), dout_w[k], 0);
                check($sformatf("rst_ovf_d%0d", k), ovf_w[k], 0);
            end else begin
                if (stall_seen[k] && out_vld_w[k]) begin
                    check($sformatf("stall_dout_d%0d", k), dout_w[k], held_d[k]);
                    check($sformatf("stall_ovf_d%0d", k), ovf_w[k], held_o[k]);
                end
                stall_seen[k] = out_vld_w[k] && !out_rdy;
                held_d[k]     = dout_w[k];
                held_o[k]     = ovf_w[k];
                if (!out_vld_w[k]) check($sformatf("idle_ovf_d%0d", k), ovf_w[k], 0);
                if (out_vld_w[k] && out_rdy) begin
                    cons_cnt[k]++;
                    if (exp_d[k].size() == 0) begin
                        check($sformatf("extra_result_d%0d", k), exp_d[k].size(), 1);
                    end else begin
                        md = exp_d[k].pop_front();
                        mo = exp_o[k].pop_front();
                        check($sformatf("dout_d%0d", k), $signed(dout_w[k]), md);
                        check($sformatf("ovf_d%0d", k), ovf_w[k], mo);
                    end
                end
                if (in_vld && in_rdy_w[k]) begin
                    model(longint'($signed(din0)), longint'($signed(din1)), SH[k], SA[k], 25, md, mo);
                    exp_d[k].push_back(md);
                    exp_o[k].push_back(mo);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick(input int w);
        case ($urandom_range(0, 4))
            0:       return 32'(1) << (w - 1);
            1:       return (32'(1) << (w - 1)) - 1;
            2:       return '0;
            3:       return '1;
            default: return $urandom;
        endcase
    endfunction

    logic signed [63:0] cap_d [ND];
    logic               cap_o [ND];

    // One beat into empty pipes; each instance must show exactly one valid cycle at its latency.
    task automatic beat_latency(input logic [15:0] a, input logic [9:0] b);
        din0 = a; din1 = b; in_vld = 1'b1; out_rdy = 1'b1;
        step();
        in_vld = 1'b0;
        for (int c = 0; c < 7; c++) begin
            for (int k = 0; k < ND; k++) begin
                check($sformatf("latency_d%0d_c%0d", k, c), out_vld_w[k], (c == NS[k] - 1));
                if (out_vld_w[k]) begin
                    cap_d[k] = $signed(dout_w[k]);
                    cap_o[k] = ovf_w[k];
                end
            end
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    int            acc, start, nv, first_v, last_v, idle_v;
    bit            took;
    bit            pat [6] = '{1, 0, 1, 1, 0, 1};
    int            ra  [4] = '{100, 24, -24, 7};
    int            rb  [4] = '{-3, 1, 1, 1};
    int            rexp[4] = '{-19, 2, -1, 0};
    logic signed [63:0] rq [$];

    initial begin
        rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b1; din0 = '0; din1 = '0;
        repeat (3) step();
        for (int k = 0; k < ND; k++) begin
            check($sformatf("reset_in_rdy_d%0d", k), in_rdy_w[k], 1);
            check($sformatf("reset_out_vld_d%0d", k), out_vld_w[k], 0);
        end
        rst_n = 1'b1;
        step();

        // Max positive product and the most-negative corner.
        beat_latency(16'd32767, 10'd511);
        check("maxpos_dout", cap_d[0], 16743937);
        check("maxpos_ovf", cap_o[0], 0);
        beat_latency(16'h8000, 10'h200);
        check("corner_sat_dout", cap_d[0], 16777215);
        check("corner_sat_ovf", cap_o[0], 1);
        check("corner_wrap_dout", cap_d[1], -16777216);
        check("corner_wrap_ovf", cap_o[1], 1);
        check("corner_shift_dout", cap_d[2], 1048576);

        // Rounding with SHIFT=4.
        rq.delete();
        for (int c = 0; c < 14; c++) begin
            in_vld = (c < 4);
            if (c < 4) begin
                din0 = 16'(ra[c]);
                din1 = 10'(rb[c]);
            end
            step();
            if (out_vld_w[2]) begin
                rq.push_back($signed(dout_w[2]));
                check($sformatf("round_ovf_%0d", rq.size()), ovf_w[2], 0);
            end
        end
        check("round_count", rq.size(), 4);
        for (int i = 0; i < 4 && i < rq.size(); i++)
            check($sformatf("round_%0d", i), rq[i], rexp[i]);

        // Backpressure on the default instance.
        acc = 0; start = cons_cnt[0];
        din0 = 16'($urandom); din1 = 10'($urandom);
        for (int c = 0; c < 40 && acc < 8; c++) begin
            out_rdy = !(c >= 3 && c <= 5);
            in_vld  = 1'b1;
            #1;
            if (c >= 3 && c <= 6) check($sformatf("bp_in_rdy_c%0d", c), in_rdy_w[0], (c == 6));
            took = in_rdy_w[0];
            if (took) acc++;
            step();
            if (took) begin
                din0 = 16'($urandom);
                din1 = 10'($urandom);
            end
        end
        in_vld = 1'b0; out_rdy = 1'b1;
        check("bp_accepted", acc, 8);
        repeat (6) step();
        check("bp_results", cons_cnt[0] - start, 8);

        // Reset with three beats in flight in the 4-stage instance.
        for (int c = 0; c < 3; c++) begin
            din0 = 16'($urandom); din1 = 10'($urandom); in_vld = 1'b1;
            step();
        end
        in_vld = 1'b0;
        rst_n  = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            check($sformatf("midrst_out_vld_d%0d", k), out_vld_w[k], 0);
            check($sformatf("midrst_in_rdy_d%0d", k), in_rdy_w[k], 1);
        end
        #1;
        rst_n = 1'b1;
        idle_v = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (out_vld_w[3]) idle_v++;
        end
        check("midrst_stale", idle_v, 0);
        beat_latency(16'($urandom), 10'($urandom));

        // Bubble pattern and back-to-back throughput on the 3-stage instance.
        for (int j = 0; j < 12; j++) begin
            in_vld = (j < 6) ? pat[j] : 1'b0;
            din0 = 16'(pick(16)); din1 = 10'(pick(10));
            step();
            check($sformatf("bubble_j%0d", j), out_vld_w[4], (j >= 2 && j < 8) ? pat[j-2] : 1'b0);
        end
        nv = 0; first_v = -1; last_v = -1;
        for (int j = 0; j < 106; j++) begin
            in_vld = (j < 100);
            din0 = 16'(pick(16)); din1 = 10'(pick(10));
            step();
            if (out_vld_w[4]) begin
                nv++;
                if (first_v < 0) first_v = j;
                last_v = j;
            end
        end
        check("b2b_count", nv, 100);
        check("b2b_span", last_v - first_v + 1, 100);

        // Random soak with random backpressure and corner operands.
        for (int j = 0; j < 400; j++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            out_rdy = ($urandom_range(0, 2) != 0);
            din0 = 16'(pick(16)); din1 = 10'(pick(10));
            step();
        end
        in_vld = 1'b0; out_rdy = 1'b1;
        repeat (10) step();
        for (int k = 0; k < ND; k++)
            check($sformatf("drained_d%0d", k), exp_d[k].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
